// File: rtl/packet_a_to_b_bridge.sv
// -----------------------------------------------------------------------------
// packet_a_to_b_bridge
//
// Purpose:
//   Receive-side adapter between two interfaces:
//   - Producer side: push-only, valid-qualified bytes with no backpressure.
//   - Consumer side: valid/ready handshake.
//   A small first-word-fall-through FIFO absorbs consumer stalls. A push that
//   arrives while the FIFO is full, with no pop in the same cycle, is dropped.
//   Each drop sets a sticky overflow flag and increments a saturating counter.
//
// Ports:
//   clk           rising-edge clock
//   rst           synchronous reset, active-high
//   in_pkt        {data[7:0], valid}; valid=1 pushes data this cycle
//   out_data      head-of-FIFO byte, 8'h00 when empty
//   out_valid     FIFO non-empty
//   out_ready     consumer accepts out_data this cycle
//   level         current occupancy (0..DEPTH)
//   overflow      sticky flag: at least one push was dropped
//   clr_overflow  clears overflow; a drop in the same cycle wins
//   drop_cnt      number of dropped pushes, saturating at all-ones
// -----------------------------------------------------------------------------
module packet_a_to_b_bridge #(
  parameter int DEPTH = 4,
  parameter int CNT_W = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [8:0]                 in_pkt,
  output logic [7:0]                 out_data,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [$clog2(DEPTH+1)-1:0] level,
  output logic                       overflow,
  input  logic                       clr_overflow,
  output logic [CNT_W-1:0]           drop_cnt
);

  localparam int LEVEL_W = $clog2(DEPTH + 1);
  localparam int PTR_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [LEVEL_W-1:0] FULL_LEVEL = LEVEL_W'(DEPTH);

  typedef struct packed {
    logic [7:0] data;
    logic       valid;
  } packet_a_t;

  packet_a_t pkt;
  assign pkt = packet_a_t'(in_pkt);

  // State
  logic [7:0]         mem_q [DEPTH];
  logic [7:0]         mem_d [DEPTH];
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [LEVEL_W-1:0] level_q, level_d;
  logic               overflow_q, overflow_d;
  logic [CNT_W-1:0]   drop_cnt_q, drop_cnt_d;

  // Handshake decode
  logic full;
  logic pop;
  logic push;
  logic drop;

  assign out_valid = (level_q != '0);
  assign full      = (level_q == FULL_LEVEL);
  assign pop       = out_valid & out_ready;
  // A full FIFO can still take a byte when the head leaves in the same cycle.
  assign push      = pkt.valid & (~full | pop);
  assign drop      = pkt.valid & full & ~pop;

  // Fall-through read: the head entry is visible as soon as it is written.
  // No bypass, so a byte pushed this cycle is visible only after the edge.
  assign out_data  = out_valid ? mem_q[rd_ptr_q] : 8'h00;
  assign level     = level_q;
  assign overflow  = overflow_q;
  assign drop_cnt  = drop_cnt_q;

  always_comb begin
    // NOTE: every combinational output gets a default first so no latch is inferred.
    mem_d      = mem_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    level_d    = level_q;
    overflow_d = overflow_q;
    drop_cnt_d = drop_cnt_q;

    if (push) begin
      mem_d[wr_ptr_q] = pkt.data;
      // DEPTH is a power of two, so the natural pointer wrap is modulo DEPTH.
      wr_ptr_d        = wr_ptr_q + 1'b1;
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end

    unique case ({push, pop})
      2'b10:   level_d = level_q + 1'b1;
      2'b01:   level_d = level_q - 1'b1;
      default: level_d = level_q;
    endcase

    // Set has priority over clear, so a drop is never hidden by a clear.
    if (drop) begin
      overflow_d = 1'b1;
    end else if (clr_overflow) begin
      overflow_d = 1'b0;
    end

    if (drop && (drop_cnt_q != '1)) begin
      drop_cnt_d = drop_cnt_q + 1'b1;
    end
  end

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      level_q    <= '0;
      overflow_q <= 1'b0;
      drop_cnt_q <= '0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      level_q    <= level_d;
      overflow_q <= overflow_d;
      drop_cnt_q <= drop_cnt_d;
    end
  end

  // NOTE: storage is deliberately not reset. Entries are only observable when
  // level_q covers them, and out_data is forced to zero when the FIFO is empty.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

endmodule

// File: tb/tb_packet_a_to_b_bridge.sv
// -----------------------------------------------------------------------------
// tb_packet_a_to_b_bridge
//
// Directed, self-checking bench for packet_a_to_b_bridge (DEPTH=4, CNT_W=8).
// Inputs change 1 ns after each rising edge. Outputs are sampled in that same
// window, well away from the next edge.
// -----------------------------------------------------------------------------
module tb_packet_a_to_b_bridge;

  localparam int DEPTH = 4;
  localparam int CNT_W = 8;

  logic       clk = 1'b0;
  logic       rst;
  logic [8:0] in_pkt;
  logic [7:0] out_data;
  logic       out_valid;
  logic       out_ready;
  logic [2:0] level;
  logic       overflow;
  logic       clr_overflow;
  logic [7:0] drop_cnt;

  int checks   = 0;
  int failures = 0;

  packet_a_to_b_bridge #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk          (clk),
    .rst          (rst),
    .in_pkt       (in_pkt),
    .out_data     (out_data),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .level        (level),
    .overflow     (overflow),
    .clr_overflow (clr_overflow),
    .drop_cnt     (drop_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance one rising edge, then settle 1 ns into the new cycle.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [7:0] exp_bytes [4];

    rst          = 1'b1;
    in_pkt       = 9'h000;
    out_ready    = 1'b0;
    clr_overflow = 1'b0;
    step();
    step();
    rst = 1'b0;

    // Reset state
    check("rst_level",    32'(level),     32'd0);
    check("rst_valid",    32'(out_valid), 32'd0);
    check("rst_data",     32'(out_data),  32'h00);
    check("rst_overflow", 32'(overflow),  32'd0);
    check("rst_dropcnt",  32'(drop_cnt),  32'd0);

    // 1. Empty + push + ready: nothing pops; byte is presented next cycle.
    in_pkt    = {8'hAA, 1'b1};
    out_ready = 1'b1;
    check("t1_empty_valid", 32'(out_valid), 32'd0);
    step();
    in_pkt = {8'hEE, 1'b0};          // data is ignored while valid=0
    check("t1_valid", 32'(out_valid), 32'd1);
    check("t1_data",  32'(out_data),  32'hAA);
    check("t1_level", 32'(level),     32'd1);
    step();
    check("t1_level_after_pop", 32'(level),     32'd0);
    check("t1_valid_after_pop", 32'(out_valid), 32'd0);
    check("t1_data_empty",      32'(out_data),  32'h00);

    // 2. Fill to DEPTH with the consumer stalled.
    out_ready = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      in_pkt = {8'(i), 1'b1};
      step();
    end
    in_pkt = 9'h000;
    check("t2_level_full", 32'(level),    32'd4);
    check("t2_overflow",   32'(overflow), 32'd0);
    check("t2_head",       32'(out_data), 32'h01);
    step();
    check("t2_head_stable", 32'(out_data), 32'h01);

    // 3. Push into a full FIFO with no pop: dropped.
    in_pkt = {8'h55, 1'b1};
    step();
    in_pkt = 9'h000;
    check("t3_overflow", 32'(overflow), 32'd1);
    check("t3_dropcnt",  32'(drop_cnt), 32'd1);
    check("t3_level",    32'(level),    32'd4);

    // 4. Full with a simultaneous pop: accepted, 0x66 goes to the tail.
    out_ready = 1'b1;
    in_pkt    = {8'h66, 1'b1};
    check("t4_pop_head", 32'(out_data), 32'h01);
    step();
    in_pkt = 9'h000;
    check("t4_level",   32'(level),    32'd4);
    check("t4_dropcnt", 32'(drop_cnt), 32'd1);

    // Drain: remaining order is 02,03,04,66. 0x55 never appears.
    exp_bytes[0] = 8'h02;
    exp_bytes[1] = 8'h03;
    exp_bytes[2] = 8'h04;
    exp_bytes[3] = 8'h66;
    for (int i = 0; i < 4; i++) begin
      check($sformatf("t4_drain_%0d", i), 32'(out_data), 32'(exp_bytes[i]));
      step();
    end
    check("t4_drained_level", 32'(level),     32'd0);
    check("t4_drained_valid", 32'(out_valid), 32'd0);

    // 5. Counter saturation and overflow clear priority.
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      in_pkt = {8'(8'h10 + i), 1'b1};
      step();
    end
    in_pkt = {8'hCC, 1'b1};
    for (int i = 0; i < 253; i++) step();      // drop count 1 -> 254
    check("t5_cnt_fe", 32'(drop_cnt), 32'hFE);
    step();                                    // drop count 255
    check("t5_cnt_ff", 32'(drop_cnt), 32'hFF);
    for (int i = 0; i < 45; i++) step();       // 300 drops in total
    check("t5_cnt_sat", 32'(drop_cnt), 32'hFF);
    clr_overflow = 1'b1;                       // clear together with a drop
    step();
    check("t5_set_wins", 32'(overflow), 32'd1);
    in_pkt = 9'h000;                           // clear alone
    step();
    clr_overflow = 1'b0;
    check("t5_cleared",   32'(overflow), 32'd0);
    check("t5_cnt_kept",  32'(drop_cnt), 32'hFF);
    check("t5_level",     32'(level),    32'd4);
    check("t5_head",      32'(out_data), 32'h10);

    // 6. Reset mid-stream with level=3 and a push pending.
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    check("t6_level3", 32'(level), 32'd3);
    rst    = 1'b1;
    in_pkt = {8'h99, 1'b1};
    step();
    rst    = 1'b0;
    in_pkt = 9'h000;
    check("t6_level",    32'(level),     32'd0);
    check("t6_valid",    32'(out_valid), 32'd0);
    check("t6_data",     32'(out_data),  32'h00);
    check("t6_overflow", 32'(overflow),  32'd0);
    check("t6_dropcnt",  32'(drop_cnt),  32'd0);
    in_pkt = {8'h77, 1'b1};
    step();
    in_pkt = 9'h000;
    check("t6_first_data", 32'(out_data), 32'h77);
    check("t6_first_lvl",  32'(level),    32'd1);
    out_ready = 1'b1;
    step();
    check("t6_popped", 32'(level), 32'd0);

    // Streaming: 1 byte/cycle with ready held high, level steady at 1.
    for (int i = 0; i < 4; i++) begin
      in_pkt = {8'(8'h20 + i), 1'b1};
      if (i > 0) begin
        check($sformatf("stream_data_%0d", i), 32'(out_data), 32'(8'h20 + i - 1));
        check($sformatf("stream_lvl_%0d", i),  32'(level),    32'd1);
      end
      step();
    end
    in_pkt = 9'h000;
    check("stream_last", 32'(out_data), 32'h23);
    step();
    check("stream_empty", 32'(out_valid), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
